muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO result registers. Sits directly
//  downstream of the general register file and consumes its rs/rt read data
//  (rs1, rt1). Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the 64-bit
//  result for MFHI/MFLO. Asserts busy so the controller stalls dependent ops.
// PARAMETERS
//  MUL_CYCLES  5   cycles busy for MULT/MULTU (>=1); product computed on entry
//  DIV_CYCLES  32  cycles busy for DIV/DIVU; fixed at 32 (radix-2 restoring)
// PORTS
//  clk    in   1   clock, all state updates on rising edge
//  reset  in   1   synchronous, active-high reset
//  start  in   1   request: sample op/rs1/rt1 at this edge
//  op     in   3   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//  rs1    in   32  operand A / dividend / MTHI-MTLO source (from GPR rs port)
//  rt1    in   32  operand B / divisor (from GPR rt port)
//  busy   out  1   operation in progress; new starts ignored
//  done   out  1   one-cycle pulse: hi/lo were just updated (or div-by-0 ended)
//  hi     out  32  HI register
//  lo     out  32  LO register
// BEHAVIOUR
//  - Reset (any state, incl. mid-operation): hi=0, lo=0, busy=0, done=0,
//    counter=0, FSM->IDLE; in-flight result discarded.
//  - FSM states: IDLE, MUL, DIV. Only IDLE accepts start.
//  - IDLE, start=1 at edge N with op MULT/MULTU: latch 64-bit product
//    (signed for MULT, unsigned for MULTU), busy<=1, FSM->MUL, cnt<=MUL_CYCLES.
//  - IDLE, start=1 at edge N with DIV/DIVU: latch |A|,|B| (DIV) or raw (DIVU)
//    and result signs, busy<=1, FSM->DIV, cnt<=32; one quotient bit per cycle.
//  - MUL/DIV: cnt decrements each edge; at edge N+L (L=MUL_CYCLES or 32):
//    hi/lo written, busy<=0, done<=1, FSM->IDLE. busy high exactly L cycles.
//    done low again at edge N+L+1 unless another op completes.
//  - hi/lo keep their old values while busy; intermediate state never visible.
//  - MTHI/MTLO in IDLE: hi (or lo) <= rs1 at edge N; busy stays 0;
//    done=1 for cycle N+1 only. Other register untouched.
//  - op 110/111: no-op, no busy, no done.
//  - start while busy: ignored entirely (operands not sampled, op not queued).
//  - Start accepted in the cycle after done (IDLE back-to-back allowed).
//  - Multiply: hi = product[63:32], lo = product[31:0].
//  - DIVU: lo = A/B, hi = A%B unsigned.
//  - DIV: quotient truncated toward zero; remainder has sign of dividend;
//    magnitudes divided then negated. 0x80000000 / -1 -> lo=0x80000000, hi=0.
//  - Divide by zero (B==0, DIV or DIVU): full 32-cycle busy, done pulses,
//    hi and lo UNCHANGED.
// TESTING
//  1. Assert reset 2 cycles -> hi=0, lo=0, busy=0, done=0.
//  2. MULTU A=B=0xFFFFFFFF -> busy 5 cycles, then hi=0xFFFFFFFE,
//     lo=0x00000001, done pulses 1 cycle.
//  3. MULT A=0xFFFFFFFD(-3) B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1;
//     MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
//  4. DIV A=-7 B=2 -> after 32 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//     DIVU A=7 B=2 -> lo=3, hi=1; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5. hi=0xAAAA0000, lo=0x5555; DIV by 0 -> hi/lo unchanged, done pulses;
//     start MULT pulsed mid-busy -> ignored, no second done.
//  6. MTHI rs1=0x12345678 -> hi=0x12345678 next edge, busy=0, lo unchanged;
//     DIVU started then reset at cycle 10 -> hi=lo=0, busy=0, no done.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/result bus between the pipeline controller and the multiply/divide unit.
// The controller drives the request side.
// The unit returns its status and the HI/LO registers.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rt1;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs1, rt1,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs1, rt1,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Multiplies form the product when the op is accepted, then hold busy for MUL_CYCLES.
// Divides use a radix-2 restoring algorithm that produces one quotient bit per cycle
// over 32 cycles.
// HI/LO change only when an operation completes, so partial results are never visible.
module muldiv_unit #(
    parameter int MUL_CYCLES = 5
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int DIV_CYCLES = 32;
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic               done_q;
    logic [63:0]        prod_q;
    logic [31:0]        quot_q;      // dividend bits shift out, quotient bits shift in
    logic [31:0]        rem_q;       // partial remainder, always < divisor
    logic [31:0]        dvs_q;       // divisor magnitude
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic               div_zero_q;

    // Control decoded by the output process
    logic               accept;
    logic               last_step;
    logic               is_mul_op;
    logic               is_div_op;

    // Operand preparation and divide step
    logic [63:0]        mul_a, mul_b, prod_d;
    logic               div_signed;
    logic [31:0]        abs_a, abs_b;
    logic [32:0]        rem_shift, diff;
    logic [31:0]        rem_d, quot_d;
    logic [31:0]        quot_fix, rem_fix;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: only IDLE accepts new work; both busy states return after their last step
    always_comb begin
        // NOTE: default assignment first, so no path through this block can infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && is_mul_op)      state_d = ST_MUL;
                else if (bus.start && is_div_op) state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: status flags, op classification and the completion strobe
    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
        is_div_op = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
        accept    = (state_q == ST_IDLE) && bus.start;
        last_step = (state_q != ST_IDLE) && (cnt_q == CNT_W'(1));
        bus.busy  = (state_q != ST_IDLE);
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

    // Operand conditioning: sign/zero extension for multiply, magnitudes for divide
    always_comb begin
        mul_a      = {{32{(bus.op == OP_MULT) & bus.rs1[31]}}, bus.rs1};
        mul_b      = {{32{(bus.op == OP_MULT) & bus.rt1[31]}}, bus.rt1};
        // Low 64 bits of the extended product are exact for both signed and unsigned operands
        prod_d     = mul_a * mul_b;
        div_signed = (bus.op == OP_DIV);
        abs_a      = (div_signed && bus.rs1[31]) ? (32'd0 - bus.rs1) : bus.rs1;
        abs_b      = (div_signed && bus.rt1[31]) ? (32'd0 - bus.rt1) : bus.rt1;
    end

    // One restoring-division step, plus sign correction of the final result
    always_comb begin
        rem_shift = {rem_q, quot_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (!diff[32]) begin
            rem_d  = diff[31:0];
            quot_d = {quot_q[30:0], 1'b1};
        end else begin
            rem_d  = rem_shift[31:0];
            quot_d = {quot_q[30:0], 1'b0};
        end
        // Magnitudes are divided, then negated, so the quotient truncates toward zero
        quot_fix = neg_quot_q ? (32'd0 - quot_d) : quot_d;
        rem_fix  = neg_rem_q  ? (32'd0 - rem_d)  : rem_d;
    end

    // Datapath: latch operands on accept, iterate, and commit HI/LO on the last step
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            prod_q     <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (is_mul_op) begin
                    prod_q <= prod_d;
                    cnt_q  <= CNT_W'(MUL_CYCLES);
                end else if (is_div_op) begin
                    quot_q     <= abs_a;
                    rem_q      <= '0;
                    dvs_q      <= abs_b;
                    neg_quot_q <= div_signed & (bus.rs1[31] ^ bus.rt1[31]);
                    neg_rem_q  <= div_signed & bus.rs1[31];
                    div_zero_q <= (bus.rt1 == 32'd0);
                    cnt_q      <= CNT_W'(DIV_CYCLES);
                end else if (bus.op == OP_MTHI) begin
                    hi_q   <= bus.rs1;
                    done_q <= 1'b1;
                end else if (bus.op == OP_MTLO) begin
                    lo_q   <= bus.rs1;
                    done_q <= 1'b1;
                end
            end else if (state_q == ST_MUL) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_step) begin
                    hi_q   <= prod_q[63:32];
                    lo_q   <= prod_q[31:0];
                    done_q <= 1'b1;
                end
            end else if (state_q == ST_DIV) begin
                cnt_q  <= cnt_q - CNT_W'(1);
                quot_q <= quot_d;
                rem_q  <= rem_d;
                if (last_step) begin
                    // A zero divisor still runs the full latency but leaves HI/LO intact
                    if (!div_zero_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed HI/LO, latency and strobe expectations.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    muldiv_unit_if bus ();

    muldiv_unit #(.MUL_CYCLES(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Count edges until done is seen; 0 means the bound expired
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n = k;
                break;
            end
        end
    endtask

    // Issue one op in the next cycle and check latency, strobe and HI/LO
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rt1   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (lat == 0) begin
            check({tag, "_done"}, 32'(bus.done), 32'd1);
            check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        end else begin
            check({tag, "_busy0"}, 32'(bus.busy), 32'd1);
            check({tag, "_done0"}, 32'(bus.done), 32'd0);
            wait_done(n);
            check({tag, "_lat"}, 32'(n), 32'(lat));
            check({tag, "_busy1"}, 32'(bus.busy), 32'd0);
        end
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    // Count done pulses over a window of cycles
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
    endtask

    initial begin
        int n;
        int pulses;
        n_vec     = 0;
        n_miss    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.rs1   = '0;
        bus.rt1   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi",   bus.hi, 32'h0);
        check("rst_lo",   bus.lo, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multiplies, back-to-back
        do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);
        do_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'h00000005, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        do_op("multu_neg", OP_MULTU, 32'hFFFFFFFD, 32'h00000005, 5, 32'h00000004, 32'hFFFFFFF1);
        do_op("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h00000000);

        // Divides
        do_op("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu_7_2",   OP_DIVU, 32'h00000007, 32'h00000002, 32, 32'h00000001, 32'h00000003);
        do_op("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32, 32'h00000000, 32'h80000000);
        do_op("div_7_m2",   OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32, 32'h00000001, 32'hFFFFFFFD);
        do_op("divu_big",   OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32, 32'h0000000F, 32'h0FFFFFFF);

        // Moves to HI/LO
        do_op("mthi_a", OP_MTHI, 32'hAAAA0000, 32'h0, 0, 32'hAAAA0000, 32'h0FFFFFFF);
        do_op("mtlo_5", OP_MTLO, 32'h00005555, 32'h0, 0, 32'hAAAA0000, 32'h00005555);

        // Reserved op: no busy, no done, registers untouched
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b110;
        bus.rs1   = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("nop_busy", 32'(bus.busy), 32'd0);
        check("nop_done", 32'(bus.done), 32'd0);
        check("nop_hi",   bus.hi, 32'hAAAA0000);
        check("nop_lo",   bus.lo, 32'h00005555);

        // Divide by zero with a MULT start pulsed while busy
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.rs1   = 32'h00001234;
        bus.rt1   = 32'h00000000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("dz_busy0", 32'(bus.busy), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.rs1   = 32'h00000003;
        bus.rt1   = 32'h00000003;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("dz_busy_mid", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("dz_lat",  32'(11 + n), 32'd32);
        check("dz_busy", 32'(bus.busy), 32'd0);
        check("dz_hi",   bus.hi, 32'hAAAA0000);
        check("dz_lo",   bus.lo, 32'h00005555);
        count_done(40, pulses);
        check("dz_extra_done", 32'(pulses), 32'd0);
        check("dz_idle",  32'(bus.busy), 32'd0);
        check("dz_hi_end", bus.hi, 32'hAAAA0000);
        check("dz_lo_end", bus.lo, 32'h00005555);

        do_op("mthi_b", OP_MTHI, 32'h12345678, 32'h0, 0, 32'h12345678, 32'h00005555);

        // Reset in the middle of a divide
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.rs1   = 32'h00000064;
        bus.rt1   = 32'h00000007;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("rstdiv_busy0", 32'(bus.busy), 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstdiv_hi",   bus.hi, 32'h0);
        check("rstdiv_lo",   bus.lo, 32'h0);
        check("rstdiv_busy", 32'(bus.busy), 32'd0);
        check("rstdiv_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        count_done(40, pulses);
        check("rstdiv_no_done", 32'(pulses), 32'd0);
        check("rstdiv_idle",    32'(bus.busy), 32'd0);
        check("rstdiv_hi_end",  bus.hi, 32'h0);

        // Unit still works after the abort
        do_op("divu_post", OP_DIVU, 32'h00000064, 32'h00000007, 32, 32'h00000002, 32'h0000000E);
        @(posedge clk);
        #1;
        check("final_done_low", 32'(bus.done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
